// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and the legality check used by the
// command queue to mask results of undefined operations.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    MUL = 4'd2,
    DIV = 4'd3,
    AND = 4'd4,
    OR  = 4'd5,
    NOT = 4'd6,
    SLL = 4'd7,
    SRL = 4'd8
  } alu_op_e;

  // Codes above SRL (9..15) are undefined.
  function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
    return op <= SRL;
  endfunction

endpackage

// File: rtl/alu_cmd_queue_if.sv
// Bundle of the command, ALU and result handshakes around alu_cmd_queue.
// The master side is the environment; the slave side is the queue itself.
interface alu_cmd_queue_if
  import alu_pkg::*;
#(
  parameter int N = 8
);

  logic                in_valid;
  logic                in_ready;
  logic [N-1:0]        in_a;
  logic [N-1:0]        in_b;
  logic [ALU_OP_W-1:0] in_op;

  logic [N-1:0]        alu_a;
  logic [N-1:0]        alu_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic [N-1:0]        alu_result;

  logic                out_valid;
  logic                out_ready;
  logic [N-1:0]        out_result;
  logic [ALU_OP_W-1:0] out_op;
  logic                out_err;

  modport master (
    output in_valid, in_a, in_b, in_op,
    input  in_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result,
    input  out_valid, out_result, out_op, out_err,
    output out_ready
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op,
    output in_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result,
    output out_valid, out_result, out_op, out_err,
    input  out_ready
  );

endinterface

// File: rtl/cmd_fifo.sv
// Circular command buffer with free-running wrap pointers and an occupancy
// counter; the head entry is driven combinationally from storage.
module cmd_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_cmd_queue.sv
// Command queue in front of the combinational ALU plus a result register
// behind it, giving the ALU valid/ready flow control on both sides.
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  alu_cmd_queue_if.slave bus
);

  localparam int W  = 2*N + ALU_OP_W;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]        head;
  logic [ALU_OP_W-1:0] head_op;
  logic [CW-1:0]       count;
  logic                full, empty, push, pop, head_legal;

  logic                out_valid_q,  out_valid_d;
  logic [N-1:0]        out_result_q, out_result_d;
  logic [ALU_OP_W-1:0] out_op_q,     out_op_d;
  logic                out_err_q,    out_err_d;

  // in_ready looks only at occupancy, so a pop never opens a same-cycle push.
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;
  assign pop          = !empty && (!out_valid_q || bus.out_ready);

  cmd_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({bus.in_op, bus.in_a, bus.in_b}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign {head_op, bus.alu_a, bus.alu_b} = head;
  assign bus.alu_op = head_op;
  assign head_legal = alu_op_legal(head_op);

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_op_d     = out_op_q;
    out_err_d    = out_err_q;
    if (pop) begin
      out_valid_d  = 1'b1;
      out_result_d = head_legal ? bus.alu_result : '0;
      out_op_d     = head_op;
      out_err_d    = !head_legal;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_op_q     <= '0;
      out_err_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_op_q     <= out_op_d;
      out_err_q    <= out_err_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_op     = out_op_q;
  assign bus.out_err    = out_err_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_C);

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue: single-command vector table, then fill,
// back-pressure, wrap-around and mid-stream reset sequences.
module tb_alu_cmd_queue;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_cmd_queue_if #(.N(N)) bus ();

  alu_cmd_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; undefined codes return a non-zero pattern so masking shows.
  function automatic logic [N-1:0] alu_ref(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return (b == '0) ? '1 : a / b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return ~a;
      4'd7:    return a << b;
      4'd8:    return a >> b;
      default: return N'(8'hEE);
    endcase
  endfunction

  always_comb bus.alu_result = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   op;
    logic [N-1:0] res;
    logic         err;
  } vec_t;

  vec_t         vt [13];
  logic [N-1:0] fa [6];
  logic [N-1:0] fb [6];
  logic [3:0]   fop[6];
  logic [N-1:0] fexp[5];
  logic [N-1:0] expq[$];
  int           got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [3:0] op);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{8'h05, 8'h03, 4'd0, 8'h08, 1'b0};
    vt[1]  = '{8'h09, 8'h04, 4'd1, 8'h05, 1'b0};
    vt[2]  = '{8'h07, 8'h06, 4'd2, 8'h2A, 1'b0};
    vt[3]  = '{8'h64, 8'h07, 4'd3, 8'h0E, 1'b0};
    vt[4]  = '{8'hF0, 8'h3C, 4'd4, 8'h30, 1'b0};
    vt[5]  = '{8'hF0, 8'h0F, 4'd5, 8'hFF, 1'b0};
    vt[6]  = '{8'h5A, 8'h00, 4'd6, 8'hA5, 1'b0};
    vt[7]  = '{8'h01, 8'h03, 4'd7, 8'h08, 1'b0};
    vt[8]  = '{8'h80, 8'h04, 4'd8, 8'h08, 1'b0};
    vt[9]  = '{8'h01, 8'h01, 4'hA, 8'h00, 1'b1};
    vt[10] = '{8'h10, 8'h10, 4'd2, 8'h00, 1'b0};
    vt[11] = '{8'h03, 8'h04, 4'hF, 8'h00, 1'b1};
    vt[12] = '{8'hFF, 8'h02, 4'd0, 8'h01, 1'b0};

    fa  = '{8'h09, 8'hF0, 8'h01, 8'h02, 8'h01, 8'h40};
    fb  = '{8'h04, 8'h3C, 8'h03, 8'h02, 8'h02, 8'h02};
    fop = '{4'd1,  4'd4,  4'd7,  4'd0,  4'd5,  4'd8};
    fexp = '{8'h30, 8'h08, 8'h04, 8'h03, 8'h10};

    drive(1'b0, '0, '0, '0);
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready),   32'd1);
    chk("rst_out_valid", 32'(bus.out_valid),  32'd0);
    chk("rst_out_result",32'(bus.out_result), 32'd0);
    chk("rst_out_op",    32'(bus.out_op),     32'd0);
    chk("rst_out_err",   32'(bus.out_err),    32'd0);
    rst_n = 1'b1;

    // One command at a time through an idle pipeline
    bus.out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      chk("vec_idle_valid", 32'(bus.out_valid), 32'd0);
      drive(1'b1, vt[i].a, vt[i].b, vt[i].op);
      @(negedge clk);
      drive(1'b0, '0, '0, '0);
      chk("vec_latency_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      chk("vec_valid",  32'(bus.out_valid),  32'd1);
      chk("vec_result", 32'(bus.out_result), 32'(vt[i].res));
      chk("vec_op",     32'(bus.out_op),     32'(vt[i].op));
      chk("vec_err",    32'(bus.out_err),    32'(vt[i].err));
    end
    @(negedge clk);
    chk("vec_final_clear", 32'(bus.out_valid), 32'd0);

    // Fill with the consumer stalled: one result register plus DEPTH slots
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("fill_in_ready", 32'(bus.in_ready), 32'd1);
      drive(1'b1, fa[k], fb[k], fop[k]);
    end
    @(negedge clk);
    chk("full_in_ready",   32'(bus.in_ready),   32'd0);
    chk("full_out_valid",  32'(bus.out_valid),  32'd1);
    chk("full_out_result", 32'(bus.out_result), 32'h05);
    drive(1'b1, fa[5], fb[5], fop[5]);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready),   32'd0);
      chk("bp_result",   32'(bus.out_result), 32'h05);
      chk("bp_op",       32'(bus.out_op),     32'd1);
      chk("bp_valid",    32'(bus.out_valid),  32'd1);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("drain_valid",  32'(bus.out_valid),  32'd1);
      chk("drain_result", 32'(bus.out_result), 32'(fexp[k]));
      if (k == 0) chk("push_after_pop_ready", 32'(bus.in_ready), 32'd1);
      if (k == 1) drive(1'b0, '0, '0, '0);
    end
    @(negedge clk);
    chk("drain_done_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_done_ready", 32'(bus.in_ready),  32'd1);

    // Steady push+pop at two entries, 12 commands across pointer wrap
    bus.out_ready = 1'b0;
    got = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 3) bus.out_ready = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        chk("wrap_result", 32'(bus.out_result), 32'(expq.pop_front()));
        got++;
      end
      if (k >= 3) chk("wrap_in_ready", 32'(bus.in_ready), 32'd1);
      drive(1'b1, N'(3*k + 1), N'(k), 4'd0);
      expq.push_back(N'(4*k + 1));
    end
    for (int t = 0; t < 20 && got < 12; t++) begin
      @(negedge clk);
      if (t == 0) drive(1'b0, '0, '0, '0);
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() > 0) begin
          chk("wrap_result", 32'(bus.out_result), 32'(expq.pop_front()));
        end else begin
          n_cmp++;
          n_bad++;
          $display("FAIL wrap_extra: got unexpected result %0h expected none", bus.out_result);
        end
        got++;
      end
    end
    chk("wrap_count", 32'(got), 32'd12);
    @(negedge clk);
    chk("wrap_idle_valid", 32'(bus.out_valid), 32'd0);

    // Reset with a pending result and three queued commands
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) drive(1'b1, 8'h09, 8'h02, 4'd1);
      else        drive(1'b1, N'(k), N'(k), 4'd0);
    end
    @(negedge clk);
    drive(1'b0, '0, '0, '0);
    chk("pre_rst_valid",  32'(bus.out_valid),  32'd1);
    chk("pre_rst_result", 32'(bus.out_result), 32'h07);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",  32'(bus.out_valid),  32'd0);
    chk("mid_rst_ready",  32'(bus.in_ready),   32'd1);
    chk("mid_rst_result", 32'(bus.out_result), 32'd0);
    chk("mid_rst_op",     32'(bus.out_op),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
    end
    drive(1'b1, 8'h05, 8'h03, 4'd0);
    @(negedge clk);
    drive(1'b0, '0, '0, '0);
    chk("post_rst_latency", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("post_rst_valid",  32'(bus.out_valid),  32'd1);
    chk("post_rst_result", 32'(bus.out_result), 32'h08);
    chk("post_rst_op",     32'(bus.out_op),     32'd0);
    @(negedge clk);
    chk("post_rst_clear",  32'(bus.out_valid),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
